speed_pi_loop: RTL and testbench
================================

// Module: speed_pi_loop
// PURPOSE
// - Clocked, parametrised speed-loop PI controller for the FOC outer loop: speed_ref/speed in, torque_ref out.
// - Runtime gains and torque limit, back-calculation anti-windup, one shared multiplier sequenced by an FSM.
// - One update per sample strobe; feeds the current-loop reference input.
// PARAMETERS
// - N      10  signed data width (ref, speed, gains, limit, torque_ref)
// - F       9  fractional bits; Q(N-F).F fixed point
// - ACC_W  16  integrator width (>= N+2)
// PORTS
// - clk           in   1    system clock
// - rst_n         in   1    synchronous active-low reset
// - en            in   1    loop enable; 0 clears integrator and holds torque_ref at 0
// - sample_valid  in   1    one-cycle strobe: start an update
// - speed_ref     in   N    signed speed reference, sampled on sample_valid
// - speed         in   N    signed measured speed, sampled on sample_valid
// - kp, ki, kaw   in   N    signed gains, Q.F, sampled on sample_valid
// - torque_lim    in   N-1  unsigned magnitude limit; output clamped to [-lim, +lim]
// - torque_ref    out  N    signed torque reference, registered
// - torque_valid  out  1    one-cycle pulse when torque_ref updates
// - busy          out  1    high from sample accept until torque_valid
// - saturated     out  1    registered with torque_ref: unclamped u was outside limit
// - overrun       out  1    sticky: sample_valid seen while busy; cleared only by reset
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): all outputs 0, integrator 0, FSM IDLE.
// - FSM: IDLE -> ERR -> PROP -> SUM -> INTEG -> IDLE. IDLE accepts sample_valid when en=1.
// - ERR:   e = speed_ref - speed, N+1 bits, no overflow.
// - PROP:  p = (kp*e) >>> F (arithmetic shift, floor).
// - SUM:   u = p + i_acc[ACC_W-1:?]; u_sat = clamp(u, +/-torque_lim); torque_ref<=u_sat,
//          saturated<=(u!=u_sat), torque_valid pulses this cycle.
// - INTEG: i_acc += ((ki*e) + kaw*(u_sat-u)) >>> F; result clamped to ACC_W signed range.
// - Integrator is held at integer scale aligned to torque_ref (same LSB); ACC_W-N guard bits.
// - Latency: sample_valid at cycle T -> torque_valid at T+3; busy high T+1..T+4; next sample accepted at T+5.
// - sample_valid while busy: ignored, overrun<=1, in-flight update unaffected.
// - en=0: FSM forced to IDLE next edge, i_acc<=0, torque_ref<=0, saturated<=0; no torque_valid.
// - en falling mid-update: update aborted, no torque_valid.
// - torque_lim=0: torque_ref=0, saturated=1 whenever u!=0.
// - Negative limit symmetric: clamp is to -torque_lim, never to -2^(N-1).
// CONFIGURATION
// - SPEED_PI_RAMP_EN defined: speed_ref passes through a slew limiter before ERR; per accepted sample the
//   effective reference moves toward speed_ref by at most RAMP_STEP (parameter, default 4 LSB);
//   ramp state reset to 0 by rst_n and by en=0. Latency unchanged.
// - SPEED_PI_RAMP_EN undefined: speed_ref used directly; no ramp state, RAMP_STEP unused.
// STRUCTURE
// - foc_pkg: typedef q_t (logic signed [N-1:0]), pi_state_e enum (IDLE, ERR, PROP, SUM, INTEG),
//   function sat_signed(value, lim) shared with the current loop.
// - One sub-module: pi_mac (registered signed multiply + shift-accumulate), reused in PROP and INTEG.
// TESTING
// - rst_n=0 with en=1, sample_valid=1 -> all outputs 0, no torque_valid while in reset.
// - kp=256 (0.5), ki=kaw=0, lim=400, ref=100, speed=0, strobe -> torque_valid at T+3, torque_ref=50.
// - kp=0, ki=51, ref=100, speed=0, 10 strobes -> torque_ref follows floor-accumulated i_acc,
//   +9 per strobe (51*100>>>9) -> 0,9,18,...,81 (pre-integ output).
// - kp=511, ki=256, kaw=256, lim=100, err=400 for 20 strobes -> torque_ref=100, saturated=1,
//   then err=-50 -> torque_ref leaves limit within 2 strobes (anti-windup); without kaw stays >=8 strobes.
// - Strobe at T and T+2 -> overrun=1 sticky, single torque_valid at T+3; then en=0 -> torque_ref=0 next edge.
// - SPEED_PI_RAMP_EN, RAMP_STEP=4, kp=511, ref step 0->40 -> effective error grows 4 per strobe, reaches 40 at strobe 10.

Source files
------------

// File: rtl/foc_pkg.sv
// foc_pkg: types and helpers shared by the FOC control loops.
//   q_t         default-width signed fixed-point sample (Q1.9)
//   pi_state_e  PI update sequencer states
//   sat_signed  symmetric clamp of a signed value to [-lim, +lim]
package foc_pkg;

   localparam int Q_N = 10;
   localparam int Q_F = 9;

   typedef logic signed [Q_N-1:0] q_t;

   typedef enum logic [2:0] {
      IDLE,
      ERR,
      PROP,
      SUM,
      INTEG
   } pi_state_e;

   // The negative bound is -lim, never the most negative code, so the clamp
   // stays symmetric for every limit.
   function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input logic        [31:0] lim);
      logic signed [31:0] hi;
      hi = signed'(lim);
      if (value > hi)
         return hi;
      else if (value < -hi)
         return -hi;
      else
         return value;
   endfunction

endpackage

// File: rtl/speed_pi_loop_mac.sv
// pi_mac: registered signed multiply with shift-accumulate, time-shared by
// the speed PI sequencer.
//   clk, rst_n  clock, synchronous active-low reset
//   en          register the new sum this cycle
//   load        1: sum = a*b ; 0: sum = acc + a*b
//   a, b        signed operands
//   acc_sh      registered accumulator >>> F (floor)
//   sum_sh      combinational (base + a*b) >>> F (floor)
module pi_mac #(
   parameter int AW = 10,
   parameter int BW = 18,
   parameter int F  = 9,
   parameter int MW = AW + BW + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 load,
   input  logic signed [AW-1:0] a,
   input  logic signed [BW-1:0] b,
   output logic signed [MW-1:0] acc_sh,
   output logic signed [MW-1:0] sum_sh
);

   logic signed [MW-1:0] acc;
   logic signed [MW-1:0] prod;
   logic signed [MW-1:0] base;
   logic signed [MW-1:0] sum;

   always_comb begin
      // Extend before multiplying so the product is formed at full width.
      prod   = MW'(a) * MW'(b);
      base   = load ? '0 : acc;
      sum    = base + prod;
      acc_sh = acc >>> F;
      sum_sh = sum >>> F;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         acc <= '0;
      else if (en)
         acc <= sum;
   end

endmodule

// File: rtl/speed_pi_loop.sv
// speed_pi_loop: sequenced speed-loop PI controller (speed error -> torque
// reference) with runtime gains, symmetric torque limit and back-calculation
// anti-windup. One shared multiplier: kp*e in PROP, ki*e in SUM, kaw*(u_sat-u)
// accumulated in INTEG.
//   clk, rst_n           clock, synchronous active-low reset
//   en                   loop enable; low clears integrator and torque_ref
//   sample_valid         one-cycle start strobe (accepted in IDLE with en=1)
//   speed_ref, speed     signed Q.F speed reference and measurement
//   kp, ki, kaw          signed Q.F gains
//   torque_lim           unsigned magnitude limit
//   torque_ref           registered signed torque reference
//   torque_valid         one-cycle pulse on torque_ref update
//   busy                 update in flight
//   saturated            unclamped output exceeded the limit
//   overrun              sticky: strobe arrived while busy
// Build option: SPEED_PI_RAMP_EN adds a per-sample slew limiter (RAMP_STEP)
// on speed_ref ahead of the error stage.
module speed_pi_loop
   import foc_pkg::*;
#(
   parameter int N = Q_N,
   parameter int F = Q_F,
`ifdef SPEED_PI_RAMP_EN
   parameter int RAMP_STEP = 4,
`endif
   parameter int ACC_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                sample_valid,
   input  logic signed [N-1:0] speed_ref,
   input  logic signed [N-1:0] speed,
   input  logic signed [N-1:0] kp,
   input  logic signed [N-1:0] ki,
   input  logic signed [N-1:0] kaw,
   input  logic        [N-2:0] torque_lim,
   output logic signed [N-1:0] torque_ref,
   output logic                torque_valid,
   output logic                busy,
   output logic                saturated,
   output logic                overrun
);

   localparam int BW = ACC_W + 2;
   localparam int MW = N + BW + 1;
   localparam logic signed [31:0] I_MAX = 32'(2**(ACC_W-1) - 1);
   localparam logic signed [31:0] I_MIN = -I_MAX - 32'sd1;

   pi_state_e state;

   logic signed [N-1:0]     ref_r, speed_r, kp_r, ki_r, kaw_r;
   logic        [N-2:0]     lim_r;
   logic signed [N:0]       e_r;
   logic signed [BW-1:0]    d_r;
   logic signed [ACC_W-1:0] i_acc;

   logic signed [N-1:0]     ref_eff;
   logic signed [N-1:0]     mac_a;
   logic signed [BW-1:0]    mac_b;
   logic                    mac_en, mac_load;
   logic signed [MW-1:0]    mac_acc_sh, mac_sum_sh;
   logic signed [31:0]      u, u_sat, i_sum;
   logic signed [ACC_W-1:0] i_next;

`ifdef SPEED_PI_RAMP_EN
   localparam logic signed [N:0] RS = (N+1)'(RAMP_STEP);

   logic signed [N-1:0] ramp_ref, ramp_next;
   logic signed [N:0]   ramp_diff;

   always_comb begin
      ramp_diff = (N+1)'(speed_ref) - (N+1)'(ramp_ref);
      if (ramp_diff > RS)
         ramp_next = ramp_ref + N'(RAMP_STEP);
      else if (ramp_diff < -RS)
         ramp_next = ramp_ref - N'(RAMP_STEP);
      else
         ramp_next = speed_ref;
      ref_eff = ramp_next;
   end
`else
   always_comb ref_eff = speed_ref;
`endif

   // Multiplier schedule: PROP loads kp*e (read in SUM), SUM loads ki*e,
   // INTEG adds kaw*(u_sat-u) and the combinational sum feeds the integrator.
   always_comb begin
      mac_a    = kp_r;
      mac_b    = BW'(e_r);
      mac_en   = 1'b0;
      mac_load = 1'b1;
      case (state)
         PROP: begin
            mac_en = en;
         end
         SUM: begin
            mac_a  = ki_r;
            mac_en = en;
         end
         INTEG: begin
            mac_a    = kaw_r;
            mac_b    = d_r;
            mac_en   = en;
            mac_load = 1'b0;
         end
         default: ;
      endcase
   end

   pi_mac #(
      .AW (N),
      .BW (BW),
      .F  (F),
      .MW (MW)
   ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (mac_en),
      .load   (mac_load),
      .a      (mac_a),
      .b      (mac_b),
      .acc_sh (mac_acc_sh),
      .sum_sh (mac_sum_sh)
   );

   always_comb begin
      u     = 32'(mac_acc_sh) + 32'(i_acc);
      u_sat = sat_signed(u, 32'(lim_r));
      i_sum = 32'(i_acc) + 32'(mac_sum_sh);
      if (i_sum > I_MAX)
         i_next = ACC_W'(I_MAX);
      else if (i_sum < I_MIN)
         i_next = ACC_W'(I_MIN);
      else
         i_next = ACC_W'(i_sum);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         ref_r        <= '0;
         speed_r      <= '0;
         kp_r         <= '0;
         ki_r         <= '0;
         kaw_r        <= '0;
         lim_r        <= '0;
         e_r          <= '0;
         d_r          <= '0;
         i_acc        <= '0;
         torque_ref   <= '0;
         torque_valid <= 1'b0;
         busy         <= 1'b0;
         saturated    <= 1'b0;
         overrun      <= 1'b0;
`ifdef SPEED_PI_RAMP_EN
         ramp_ref     <= '0;
`endif
      end else begin
         torque_valid <= 1'b0;
         if (sample_valid && busy)
            overrun <= 1'b1;
         if (!en) begin
            // Disable aborts any update in flight and drops the output.
            state      <= IDLE;
            busy       <= 1'b0;
            i_acc      <= '0;
            torque_ref <= '0;
            saturated  <= 1'b0;
`ifdef SPEED_PI_RAMP_EN
            ramp_ref   <= '0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (sample_valid) begin
                     ref_r   <= ref_eff;
                     speed_r <= speed;
                     kp_r    <= kp;
                     ki_r    <= ki;
                     kaw_r   <= kaw;
                     lim_r   <= torque_lim;
                     busy    <= 1'b1;
                     state   <= ERR;
`ifdef SPEED_PI_RAMP_EN
                     ramp_ref <= ramp_next;
`endif
                  end
               end
               ERR: begin
                  e_r   <= (N+1)'(ref_r) - (N+1)'(speed_r);
                  state <= PROP;
               end
               PROP: begin
                  state <= SUM;
               end
               SUM: begin
                  torque_ref   <= N'(u_sat);
                  saturated    <= (u != u_sat);
                  torque_valid <= 1'b1;
                  d_r          <= BW'(u_sat - u);
                  state        <= INTEG;
               end
               INTEG: begin
                  i_acc <= i_next;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_speed_pi_loop.sv
// tb_speed_pi_loop: scoreboard bench for speed_pi_loop. Stimulus pushes the
// expected torque_ref/saturated per accepted sample; an independent monitor
// pops and compares on every torque_valid pulse.
// Honours SPEED_PI_RAMP_EN (ramp test added, hand values replaced by model).
module tb_speed_pi_loop;

   localparam int N  = 10;
   localparam int F  = 9;
`ifdef SPEED_PI_RAMP_EN
   localparam bit HAND = 1'b0;
   localparam int STEP = 4;
`else
   localparam bit HAND = 1'b1;
`endif

   logic                clk;
   logic                rst_n;
   logic                en;
   logic                sample_valid;
   logic signed [N-1:0] speed_ref, speed, kp, ki, kaw;
   logic        [N-2:0] torque_lim;
   logic signed [N-1:0] torque_ref;
   logic                torque_valid, busy, saturated, overrun;

   typedef struct {
      int t;
      int s;
   } exp_t;

   exp_t exp_q[$];
   int   tests    = 0;
   int   fails    = 0;
   int   tv_count = 0;
   int   m_i      = 0;
   int   m_ramp   = 0;

   speed_pi_loop #(.N(N), .F(F), .ACC_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .sample_valid (sample_valid),
      .speed_ref    (speed_ref),
      .speed        (speed),
      .kp           (kp),
      .ki           (ki),
      .kaw          (kaw),
      .torque_lim   (torque_lim),
      .torque_ref   (torque_ref),
      .torque_valid (torque_valid),
      .busy         (busy),
      .saturated    (saturated),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Floor division by 2^F written with plain integer division.
   function automatic int floor_div(input int v);
      int q;
      q = v / (1 << F);
      if (v < 0 && q * (1 << F) != v)
         q = q - 1;
      return q;
   endfunction

   task automatic model_clear();
      m_i    = 0;
      m_ramp = 0;
   endtask

   task automatic model_step(input int r, input int sp, input int kpv, input int kiv,
                             input int kawv, input int lim, output int t, output int s);
      int eff, e, p, u, us, d;
`ifdef SPEED_PI_RAMP_EN
      if (r - m_ramp > STEP)
         m_ramp = m_ramp + STEP;
      else if (r - m_ramp < -STEP)
         m_ramp = m_ramp - STEP;
      else
         m_ramp = r;
      eff = m_ramp;
`else
      eff = r;
`endif
      e  = eff - sp;
      p  = floor_div(kpv * e);
      u  = p + m_i;
      us = (u > lim) ? lim : ((u < -lim) ? -lim : u);
      t  = us;
      s  = (u != us) ? 1 : 0;
      d  = us - u;
      m_i = m_i + floor_div(kiv * e + kawv * d);
      if (m_i > 32767)  m_i = 32767;
      if (m_i < -32768) m_i = -32768;
   endtask

   task automatic drive(input int r, input int sp, input int kpv, input int kiv,
                        input int kawv, input int lim, input bit hand, input int ht,
                        input int hs);
      int mt, ms;
      model_step(r, sp, kpv, kiv, kawv, lim, mt, ms);
      speed_ref    = N'(r);
      speed        = N'(sp);
      kp           = N'(kpv);
      ki           = N'(kiv);
      kaw          = N'(kawv);
      torque_lim   = (N-1)'(lim);
      sample_valid = 1'b1;
      if (hand && HAND)
         exp_q.push_back('{ht, hs});
      else
         exp_q.push_back('{mt, ms});
   endtask

   // Called at a negedge; returns at the negedge after edge T+4 so the next
   // call lands on the first cycle a new sample is accepted.
   task automatic strobe(input int r, input int sp, input int kpv, input int kiv,
                         input int kawv, input int lim, input bit hand, input int ht,
                         input int hs);
      drive(r, sp, kpv, kiv, kawv, lim, hand, ht, hs);
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic clear_loop();
      en = 1'b0;
      model_clear();
      @(negedge clk);
      en = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (torque_valid === 1'b1) begin
         tv_count++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_torque_valid: got pulse with torque_ref %0d, expected none",
                     torque_ref);
         end else begin
            x = exp_q.pop_front();
            check("sb_torque_ref", int'(torque_ref), x.t);
            check("sb_saturated", int'(saturated), x.s);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int tv0;
      rst_n = 1'b0; en = 1'b1; sample_valid = 1'b1;
      speed_ref = 10'sd100; speed = '0; kp = 10'sd256; ki = '0; kaw = '0;
      torque_lim = 9'd400;

      // Reset dominates enable and strobe.
      repeat (3) begin
         @(negedge clk);
         check("rst_torque_ref", int'(torque_ref), 0);
         check("rst_torque_valid", int'(torque_valid), 0);
         check("rst_busy", int'(busy), 0);
         check("rst_saturated", int'(saturated), 0);
         check("rst_overrun", int'(overrun), 0);
      end
      rst_n = 1'b1; sample_valid = 1'b0;
      @(negedge clk);

      // Latency and busy window: kp=0.5, e=100 -> 50.
      drive(100, 0, 256, 0, 0, 400, 1'b1, 50, 0);
      @(negedge clk); sample_valid = 1'b0;               // after edge T
      check("lat_busy_t", int'(busy), 1);
      check("lat_tv_t", int'(torque_valid), 0);
      @(negedge clk);                                    // after T+1
      check("lat_tv_t1", int'(torque_valid), 0);
      @(negedge clk);                                    // after T+2
      check("lat_tv_t2", int'(torque_valid), 0);
      @(negedge clk);                                    // after T+3
      check("lat_tv_t3", int'(torque_valid), 1);
      check("lat_busy_t3", int'(busy), 1);
      if (HAND) check("lat_torque_ref", int'(torque_ref), 50);
      @(negedge clk);                                    // after T+4
      check("lat_tv_t4", int'(torque_valid), 0);
      check("lat_busy_t4", int'(busy), 0);

      // Integral only: +9 per strobe, output is the pre-update integrator.
      clear_loop();
      for (int k = 0; k < 10; k++)
         strobe(100, 0, 0, 51, 0, 400, 1'b1, 9 * k, 0);

      // Boundaries: zero limit, symmetric negative clamp, floor on negatives.
      clear_loop();
      strobe(100, 0, 256, 0, 0, 0, 1'b1, 0, 1);
      strobe(100, 0, 0, 0, 0, 0, 1'b1, 0, 0);
      strobe(-400, 0, 511, 0, 0, 100, 1'b1, -100, 1);
      clear_loop();
      strobe(-101, 0, 256, 0, 0, 400, 1'b1, -51, 0);
      strobe(0, 401, 511, 0, 0, 511, 1'b1, -401, 0);

      // Anti-windup with kaw: recovers within two strobes.
      clear_loop();
      for (int k = 0; k < 20; k++)
         strobe(400, 0, 511, 256, 256, 100, 1'b0, 0, 0);
      if (HAND) begin
         check("aw_sat_torque", int'(torque_ref), 100);
         check("aw_sat_flag", int'(saturated), 1);
      end
      strobe(-50, 0, 511, 256, 256, 100, 1'b1, 50, 0);
      strobe(-50, 0, 511, 256, 256, 100, 1'b1, 25, 0);
      if (HAND) check("aw_released", int'(saturated), 0);

      // Without kaw the integrator winds up and holds the limit.
      clear_loop();
      for (int k = 0; k < 20; k++)
         strobe(400, 0, 511, 256, 0, 100, 1'b0, 0, 0);
      for (int k = 0; k < 8; k++)
         strobe(-50, 0, 511, 256, 0, 100, 1'b0, 0, 0);
      if (HAND) begin
         check("noaw_torque", int'(torque_ref), 100);
         check("noaw_sat", int'(saturated), 1);
      end

      // Overrun: second strobe at T+2 is ignored, one pulse only.
      clear_loop();
      tv0 = tv_count;
      drive(100, 0, 256, 0, 0, 400, 1'b1, 50, 0);
      @(negedge clk); sample_valid = 1'b0;
      @(negedge clk);
      speed_ref = 10'sd200; sample_valid = 1'b1;
      @(negedge clk); sample_valid = 1'b0;
      check("ovr_set", int'(overrun), 1);
      repeat (4) @(negedge clk);
      check("ovr_pulses", tv_count - tv0, 1);
      check("ovr_sticky", int'(overrun), 1);
      en = 1'b0; model_clear();
      @(negedge clk);
      check("dis_torque_ref", int'(torque_ref), 0);
      check("dis_saturated", int'(saturated), 0);
      check("dis_overrun_kept", int'(overrun), 1);
      en = 1'b1;
      @(negedge clk);

      // Enable dropped mid-update: aborted, no pulse.
      tv0 = tv_count;
      speed_ref = 10'sd100; kp = 10'sd256; sample_valid = 1'b1;
      @(negedge clk); sample_valid = 1'b0; en = 1'b0;
      @(negedge clk); en = 1'b1;
      repeat (5) @(negedge clk);
      check("abort_pulses", tv_count - tv0, 0);
      check("abort_busy", int'(busy), 0);

`ifdef SPEED_PI_RAMP_EN
      // Ramp: effective error 4,8,...,40; kp=511 -> floor(511*4k/512).
      clear_loop();
      for (int k = 1; k <= 12; k++) begin
         strobe(40, 0, 511, 0, 0, 511, 1'b0, 0, 0);
         if (k == 1)  check("ramp_first", int'(torque_ref), 3);
         if (k == 10) check("ramp_tenth", int'(torque_ref), 39);
         if (k == 12) check("ramp_hold", int'(torque_ref), 39);
      end
`endif

      repeat (3) @(negedge clk);
      check("sb_pending", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
